shift_unit_pipe: RTL
====================

// Module: shift_unit_pipe
// PURPOSE
//  Parametrised, pipelined RV32I shift execution unit (SLL/SRL/SRA, optional ROR) for the core's execute stage.
//  Replaces the single-cycle ALU shift path. Valid/ready handshake on both sides, configurable XLEN and depth.
//  Carries an opaque destination tag (rd index) alongside each result so writeback can retire out of the ALU path.
// PARAMETERS
//  XLEN    32  operand/result width; power of two, >=8
//  STAGES  2   pipeline register stages, 1..$clog2(XLEN); equals latency in cycles
//  TAG_W   5   width of pass-through tag (rd index)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-low reset
//  in_valid   in   1       request present
//  in_ready   out  1       unit accepts request this cycle
//  in_op      in   2       00 SLL, 01 SRL, 10 SRA, 11 ROR (see CONFIGURATION)
//  in_a       in   XLEN    value to shift (rs1)
//  in_b       in   XLEN    shift amount source (rs2 / imm); only low $clog2(XLEN) bits used
//  in_tag     in   TAG_W   passed through unchanged
//  out_valid  out  1       result present
//  out_ready  in   1       consumer accepts result
//  out_data   out  XLEN    shifted result
//  out_tag    out  TAG_W   tag of the request that produced out_data
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all stage valid bits 0; out_valid=0, out_data=0, out_tag=0; in_ready=1 next cycle.
//  - Transfer on a side occurs when valid && ready at posedge; requests retire strictly in order.
//  - Latency: request accepted at edge N appears on out_* after edge N+STAGES-1 (visible in cycle N+STAGES) if no stall.
//  - Throughput 1/cycle. Stage k advances when its successor is empty or advancing; last stage advances on out_ready.
//  - in_ready = !valid[0] || stage0 advancing (combinational from out_ready through the chain; no bubble required).
//  - Full pipeline with out_ready=0: in_ready=0, all stage contents and out_* held stable; no drop, no duplicate.
//  - out_valid && !out_ready: out_data/out_tag must not change until transfer.
//  - Amount: sh = in_b[$clog2(XLEN)-1:0]; sh=0 returns in_a for every op.
//  - Arithmetic: left ops implemented as bit-reverse -> right shift -> bit-reverse. Right shift fill: 0 (SRL/SLL),
//    in_a[XLEN-1] (SRA), wrapped low bits (ROR). Shift bits split across stages: stage k handles amount bits
//    [k*S .. min((k+1)*S, L)-1], S=ceil(L/STAGES), L=$clog2(XLEN); op, fill sign, residual amount carried per stage.
//  - Reset mid-operation discards all in-flight requests; no result emitted for them.
//  - Simultaneous in and out transfer on a full pipe: legal, occupancy unchanged.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined: op 11 = rotate right by sh (Zbb ROR semantics).
//  SHIFT_ROTATE_EN undefined: op 11 decoded as SRL; no rotate wrap logic synthesised.
// STRUCTURE
//  shift_pkg: op encoding localparams (OP_SLL/OP_SRL/OP_SRA/OP_ROR), stage payload struct-equivalent field widths,
//   SHAMT_W = $clog2(XLEN) function.
//  Sub-module shift_stage: one registered stage (payload regs + partial barrel shift + valid/advance logic);
//   top instantiates STAGES copies via generate, plus input reverse and output un-reverse.
// TESTING
//  1. XLEN=32, SLL a=20 b=4 tag=3 -> out_data=0x0000_0140 (320), out_tag=3, after exactly STAGES cycles.
//  2. SRA a=0x8000_0000 b=31 -> 0xFFFF_FFFF; SRL same operands -> 0x0000_0001.
//  3. SLL a=1 b=36 -> amount masked to 4 -> 0x0000_0010; b=0 on each op -> out_data=a.
//  4. Stream 8 back-to-back requests, out_ready low 5 cycles mid-stream -> in_ready drops when full,
//     all 8 results in order, out_* stable while stalled, no loss/duplicates.
//  5. reset=0 for one edge with 2 requests in flight -> out_valid=0, out_data=0 next cycle, no stale result later.
//  6. ROR a=0x0000_0001 b=1: with SHIFT_ROTATE_EN -> 0x8000_0000; without -> 0x0000_0000. Repeat 1-3 with STAGES=1 and 5.

Source files
------------

// File: rtl/shift_unit_pipe_pkg.sv
// Shared definitions for the pipelined shift unit: op encodings, stage control payload, amount-width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package shift_unit_pipe_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b01;
  localparam shift_op_t OP_SRA = 2'b10;
  localparam shift_op_t OP_ROR = 2'b11;

  // Control travelling with each request; fill is the resolved fill bit for the
  // right shift (sign for SRA, 0 otherwise), so stages never look at the op for it.
  typedef struct packed {
    shift_op_t op;
    logic      fill;
  } ctl_t;

  // Number of shift-amount bits for a given datapath width.
  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

  // Amount bits handled per stage: ceil(shamt_w / stages).
  function automatic int stage_bits(input int xlen, input int stages);
    return (shamt_w(xlen) + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_unit_pipe_stage.sv
// One pipeline stage: conditional right shifts for amount bits [LO..HI-1], then a payload register.
// Latency: 1 cycle (registered output).
// Backpressure: up_rdy = stage empty or downstream taking the current entry; contents held otherwise.
// Ports: clk/reset; up_* request from previous stage; dn_* registered result to next stage.
// Optional rotate wrap (op 11) is built only when SHIFT_ROTATE_EN is defined.
module shift_unit_pipe_stage
  import shift_unit_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SW    = 5,
  parameter int LO    = 0,
  parameter int HI    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_vld,
  output logic             up_rdy,
  input  ctl_t             up_ctl,
  input  logic [SW-1:0]    up_amt,
  input  logic [XLEN-1:0]  up_dat,
  input  logic [TAG_W-1:0] up_tag,
  output logic             dn_vld,
  input  logic             dn_rdy,
  output ctl_t             dn_ctl,
  output logic [SW-1:0]    dn_amt,
  output logic [XLEN-1:0]  dn_dat,
  output logic [TAG_W-1:0] dn_tag
);

  // A stage past the end of the amount field has nothing to shift.
  localparam int NB = (HI > LO) ? (HI - LO) : 0;

  logic [XLEN-1:0] d_chain [0:NB];

  assign d_chain[0] = up_dat;

  for (genvar g = 0; g < NB; g++) begin : g_bit
    localparam int J  = LO + g;
    localparam int SH = 1 << J;
    logic [XLEN-1:0] res;

    always_comb begin
      res = d_chain[g] >> SH;
      if (up_ctl.fill) res = res | ~({XLEN{1'b1}} >> SH);
`ifdef SHIFT_ROTATE_EN
      // Low bits shifted out re-enter at the top.
      if (up_ctl.op == OP_ROR) res = res | (d_chain[g] << (XLEN - SH));
`endif
      if (!up_amt[J]) res = d_chain[g];
    end

    assign d_chain[g+1] = res;
  end

  // Accept when empty or when the current entry is leaving this cycle.
  assign up_rdy = !dn_vld || dn_rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dn_vld <= 1'b0;
      dn_ctl <= '0;
      dn_amt <= '0;
      dn_dat <= '0;
      dn_tag <= '0;
    end else if (up_rdy) begin
      dn_vld <= up_vld;
      if (up_vld) begin
        dn_ctl <= up_ctl;
        dn_amt <= up_amt;
        dn_dat <= d_chain[NB];
        dn_tag <= up_tag;
      end
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined RV32I shift unit (SLL/SRL/SRA, optional ROR) with pass-through rd tag.
// Latency: STAGES cycles, throughput 1/cycle.
// Backpressure: valid/ready both sides; in_ready combinational from out_ready through the stage chain.
// Ports: clk, reset (sync, active-low); in_valid/in_ready/in_op/in_a/in_b/in_tag request;
//        out_valid/out_ready/out_data/out_tag result.
// Build option: SHIFT_ROTATE_EN enables op 11 as rotate right; otherwise op 11 behaves as SRL.
module shift_unit_pipe
  import shift_unit_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = shamt_w(XLEN);
  localparam int S  = stage_bits(XLEN, STAGES);

  // Index 0 is the unit input, index STAGES is the last stage register.
  logic             vld [0:STAGES];
  logic             rdy [0:STAGES];
  ctl_t             ctl [0:STAGES];
  logic [SW-1:0]    amt [0:STAGES];
  logic [XLEN-1:0]  dat [0:STAGES];
  logic [TAG_W-1:0] tag [0:STAGES];

  logic [XLEN-1:0] a_rev;
  logic [XLEN-1:0] res_rev;
  ctl_t            in_ctl;

  always_comb begin
    in_ctl.op = in_op;
`ifndef SHIFT_ROTATE_EN
    if (in_op == OP_ROR) in_ctl.op = OP_SRL;
`endif
    in_ctl.fill = (in_op == OP_SRA) && in_a[XLEN-1];
  end

  // Left shifts run through the right-shift datapath on bit-reversed data.
  for (genvar i = 0; i < XLEN; i++) begin : g_rev
    assign a_rev[i]   = in_a[XLEN-1-i];
    assign res_rev[i] = dat[STAGES][XLEN-1-i];
  end

  assign vld[0] = in_valid;
  assign ctl[0] = in_ctl;
  assign amt[0] = in_b[SW-1:0];
  assign dat[0] = (in_op == OP_SLL) ? a_rev : in_a;
  assign tag[0] = in_tag;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO_K = k * S;
    localparam int HI_K = ((k + 1) * S < SW) ? (k + 1) * S : SW;

    shift_unit_pipe_stage #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W),
      .SW    (SW),
      .LO    (LO_K),
      .HI    (HI_K)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .up_vld (vld[k]),
      .up_rdy (rdy[k]),
      .up_ctl (ctl[k]),
      .up_amt (amt[k]),
      .up_dat (dat[k]),
      .up_tag (tag[k]),
      .dn_vld (vld[k+1]),
      .dn_rdy (rdy[k+1]),
      .dn_ctl (ctl[k+1]),
      .dn_amt (amt[k+1]),
      .dn_dat (dat[k+1]),
      .dn_tag (tag[k+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign out_tag   = tag[STAGES];
  // Reset leaves op=SLL and data=0, so the un-reverse still presents zero.
  assign out_data  = (ctl[STAGES].op == OP_SLL) ? res_rev : dat[STAGES];

  // Upper amount bits are ignored by definition; fill/amount are spent by the last stage.
  logic unused_bits;
  assign unused_bits = ctl[STAGES].fill ^ (^amt[STAGES]) ^ (^in_b[XLEN-1:SW]);

endmodule
